// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execute stage with valid/ready handshake
// Define ALU_SIGNED_DIV_EN for signed two's-complement DIV (default: unsigned DIV).
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic               div_zero
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [3:0] {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_ILL} op_t;

  state_t           r_state, w_state_next;
  op_t              w_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal, r_div_zero;
  logic             w_accept, w_last, w_b_zero;
  logic [WIDTH-1:0] w_simple, w_mul_sum, w_q_next, w_rem_next, w_div_res;
  logic [WIDTH:0]   w_rem_sh, w_diff;

  always_comb begin
    w_op = OP_ILL;
    if (alu_op == ALUOP_W'(3'b010)) begin
      case (funct)
        FUNCT_W'(6'b100000): w_op = OP_ADD;
        FUNCT_W'(6'b100010): w_op = OP_SUB;
        FUNCT_W'(6'b000010): w_op = OP_MUL;
        FUNCT_W'(6'b011010): w_op = OP_DIV;
        FUNCT_W'(6'b100101): w_op = OP_OR;
        FUNCT_W'(6'b100100): w_op = OP_AND;
        FUNCT_W'(6'b101010): w_op = OP_SLT;
        FUNCT_W'(6'b000000): w_op = OP_NOP;
        default:             w_op = OP_ILL;
      endcase
    end else begin
      case (alu_op)
        ALUOP_W'(3'b000): w_op = OP_ADD;
        ALUOP_W'(3'b001): w_op = OP_SUB;
        ALUOP_W'(3'b011): w_op = OP_AND;
        ALUOP_W'(3'b100): w_op = OP_OR;
        ALUOP_W'(3'b101): w_op = OP_SLT;
        default:          w_op = OP_ILL;
      endcase
    end
  end

  always_comb begin
    w_simple = '0;
    case (w_op)
      OP_ADD:  w_simple = op_a + op_b;
      OP_SUB:  w_simple = op_a - op_b;
      OP_AND:  w_simple = op_a & op_b;
      OP_OR:   w_simple = op_a | op_b;
      OP_SLT:  w_simple = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: w_simple = '0;
    endcase
  end

  // Shift-add multiply consumes r_a LSB-first; restoring divide shifts dividend MSB-first
  // out of r_a while quotient bits shift in, with r_acc holding the running remainder.
  assign w_mul_sum  = r_acc + (r_a[0] ? r_b : '0);
  assign w_rem_sh   = {r_acc, r_a[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_q_next   = {r_a[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_rem_next = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_last     = (r_cnt == CNT_W'(WIDTH-1));
  assign w_b_zero   = (op_b == '0);
  assign in_ready   = (r_state == S_IDLE);
  assign w_accept   = in_valid && in_ready;

`ifdef ALU_SIGNED_DIV_EN
  logic             r_neg;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_abs_a   = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_abs_b   = op_b[WIDTH-1] ? -op_b : op_b;
  assign w_div_res = r_neg ? -w_q_next : w_q_next;
`else
  assign w_div_res = w_q_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_op == OP_MUL)                   w_state_next = S_MUL;
        else if (w_op == OP_DIV && !w_b_zero) w_state_next = S_DIV;
        else                                  w_state_next = S_DONE;
      end
      S_MUL, S_DIV: if (w_last) w_state_next = S_DONE;
      S_DONE:       if (out_ready) w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_illegal  <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef ALU_SIGNED_DIV_EN
      r_neg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt      <= '0;
          r_acc      <= '0;
          r_illegal  <= (w_op == OP_ILL);
          r_div_zero <= (w_op == OP_DIV) && w_b_zero;
          r_result   <= ((w_op == OP_DIV) && w_b_zero) ? '1 : w_simple;
`ifdef ALU_SIGNED_DIV_EN
          r_a        <= (w_op == OP_DIV) ? w_abs_a : op_a;
          r_b        <= (w_op == OP_DIV) ? w_abs_b : op_b;
          r_neg      <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`else
          r_a        <= op_a;
          r_b        <= op_b;
`endif
        end
        S_MUL: begin
          r_acc <= w_mul_sum;
          r_a   <= r_a >> 1;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_result <= w_mul_sum;
        end
        S_DIV: begin
          r_acc <= w_rem_next;
          r_a   <= w_q_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_result <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = out_valid && (r_result == '0);
  assign illegal   = r_illegal;
  assign div_zero  = r_div_zero;

endmodule
